// File: rtl/la_capture_ctrl_if.sv
// Sample-buffer RAM port bundle between the capture sequencer (master) and the
// simple-dual-port la_ram (slave).
interface la_capture_ctrl_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport master (
        output ram_wr_addr,
        output ram_wr_data,
        output ram_wr_en,
        output ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_addr,
        input  ram_wr_data,
        input  ram_wr_en,
        input  ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: circular pre-trigger fill, masked-value
// trigger, fixed post-trigger count, then oldest-first readout of the buffer.
module la_capture_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    la_capture_ctrl_if.master     ram,
    input  logic                  rd_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  done,
    output logic                  busy
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_READ = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] pre_len;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         cnt;

    logic [CW-1:0] cnt_next;
    logic [CW-1:0] pre_ext;
    logic [CW-1:0] post_len;
    logic          hit;
    logic          capturing;
    logic          take;

    assign cnt_next  = cnt + 1'b1;
    assign pre_ext   = {1'b0, pre_len};
    assign post_len  = DEPTH_M1 - pre_ext;
    assign hit       = ((sample_in ^ value_q) & mask_q) == '0;
    assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign take      = capturing && sample_valid && !abort;

    assign done    = (state == S_DONE);
    assign busy    = capturing || (state == S_READ);
    assign rd_data = rd_valid ? ram.ram_rd_data : '0;
    assign ram.ram_rd_addr = rd_ptr;

    // Pre/post counts and readout length share one counter; abort overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            pre_len         <= '0;
            mask_q          <= '0;
            value_q         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            trig_addr       <= '0;
            rd_valid        <= 1'b0;
            rd_last         <= 1'b0;
            ram.ram_wr_en   <= 1'b0;
            ram.ram_wr_addr <= '0;
            ram.ram_wr_data <= '0;
        end else begin
            ram.ram_wr_en <= 1'b0;
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;

            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            pre_len <= pre_depth;
                            mask_q  <= trig_mask;
                            value_q <= trig_value;
                            wr_ptr  <= '0;
                            cnt     <= '0;
                            state   <= (pre_depth == '0) ? S_WAIT : S_PRE;
                        end else if ((state == S_DONE) && rd_start) begin
                            rd_ptr <= trig_addr - pre_len;
                            cnt    <= '0;
                            state  <= S_READ;
                        end
                    end
                    S_PRE: begin
                        if (sample_valid) begin
                            cnt <= cnt_next;
                            if (cnt_next == pre_ext) state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (sample_valid && hit) begin
                            trig_addr <= wr_ptr;
                            cnt       <= '0;
                            state     <= (post_len == '0) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (sample_valid) begin
                            cnt <= cnt_next;
                            if (cnt_next == post_len) state <= S_DONE;
                        end
                    end
                    S_READ: begin
                        rd_valid <= 1'b1;
                        rd_last  <= (cnt == DEPTH_M1);
                        rd_ptr   <= rd_ptr + 1'b1;
                        cnt      <= cnt_next;
                        if (cnt == DEPTH_M1) state <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end

            // Every accepted sample lands at wr_ptr one cycle later, wrapping circularly.
            if (take) begin
                ram.ram_wr_en   <= 1'b1;
                ram.ram_wr_addr <= wr_ptr;
                ram.ram_wr_data <= sample_in;
                wr_ptr          <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Randomized and directed bench for la_capture_ctrl with a queue-based model of
// captured samples and a small RAM model standing in for la_ram.
module tb_la_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          abort;
    logic [AW-1:0] pre_depth;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          rd_start;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic [AW-1:0] trig_addr;
    logic          done;
    logic          busy;

    int errors = 0;
    int checks = 0;

    la_capture_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .pre_depth    (pre_depth),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .ram          (ram_bus),
        .rd_start     (rd_start),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .trig_addr    (trig_addr),
        .done         (done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one clock after the address.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_bus.ram_wr_en) mem[ram_bus.ram_wr_addr] <= ram_bus.ram_wr_data;
        ram_bus.ram_rd_data <= mem[ram_bus.ram_rd_addr];
    end

    // Reference model: history of accepted samples since arm, trigger index into it.
    logic [DW-1:0] acc[$];
    logic [DW-1:0] rd_buf [DEPTH];
    logic [DW-1:0] seen[$];
    int            trig_idx;
    int            m_pre;
    logic [DW-1:0] m_mask;
    logic [DW-1:0] m_val;
    bit            m_cap, m_done, m_rd;
    int            ri;
    int            rd_base;
    bit            e_wr_en;
    logic [AW-1:0] e_wr_addr;
    logic [DW-1:0] e_wr_data;
    bit            e_rd_valid, e_rd_last;
    logic [DW-1:0] e_rd_data;
    logic [AW-1:0] e_trig_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc.delete();
            trig_idx = -1; m_pre = 0; m_mask = '0; m_val = '0;
            m_cap = 0; m_done = 0; m_rd = 0; ri = 0; rd_base = 0;
            e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0;
            e_rd_valid = 0; e_rd_last = 0; e_rd_data = '0; e_trig_addr = '0;
        end else begin
            e_wr_en = 0; e_rd_valid = 0; e_rd_last = 0;
            if (abort) begin
                m_cap = 0; m_done = 0; m_rd = 0;
            end else if (m_rd) begin
                e_rd_valid = 1;
                e_rd_data  = rd_buf[ri];
                e_rd_last  = (ri == DEPTH - 1);
                ri++;
                if (ri == DEPTH) begin m_rd = 0; m_done = 1; end
            end else if (!m_cap && arm) begin
                m_cap = 1; m_done = 0; acc.delete(); trig_idx = -1;
                m_pre = int'(pre_depth); m_mask = trig_mask; m_val = trig_value;
            end else if (m_done && rd_start) begin
                m_done = 0; m_rd = 1; ri = 0;
                rd_base = (acc.size() - DEPTH) % DEPTH;
                for (int i = 0; i < DEPTH; i++) rd_buf[i] = acc[acc.size() - DEPTH + i];
            end else if (m_cap && sample_valid) begin
                e_wr_en   = 1;
                e_wr_addr = AW'(acc.size() % DEPTH);
                e_wr_data = sample_in;
                if (trig_idx < 0 && acc.size() >= m_pre && ((sample_in ^ m_val) & m_mask) == '0) begin
                    trig_idx    = acc.size();
                    e_trig_addr = AW'(trig_idx % DEPTH);
                end
                acc.push_back(sample_in);
                if (trig_idx >= 0 && acc.size() == trig_idx + DEPTH - m_pre) begin
                    m_cap = 0; m_done = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("busy", 32'(busy), 32'(m_cap || m_rd));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("wr_en", 32'(ram_bus.ram_wr_en), 32'(e_wr_en));
            if (e_wr_en) begin
                checkOutput("wr_addr", 32'(ram_bus.ram_wr_addr), 32'(e_wr_addr));
                checkOutput("wr_data", 32'(ram_bus.ram_wr_data), 32'(e_wr_data));
            end
            checkOutput("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
            checkOutput("rd_last", 32'(rd_last), 32'(e_rd_last));
            if (e_rd_valid) checkOutput("rd_data", 32'(rd_data), 32'(e_rd_data));
            if (m_rd) checkOutput("rd_addr", 32'(ram_bus.ram_rd_addr), 32'((rd_base + ri) % DEPTH));
            checkOutput("trig_addr", 32'(trig_addr), 32'(e_trig_addr));
            if (rd_valid) seen.push_back(rd_data);
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] s, input logic v, input logic a,
                                 input logic ab, input logic rs);
        sample_in = s; sample_valid = v; arm = a; abort = ab; rd_start = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic armCapture(input int pre, input logic [DW-1:0] mask, input logic [DW-1:0] val);
        pre_depth = AW'(pre); trig_mask = mask; trig_value = val;
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Ramp samples with one injected value until the model reports completion.
    task automatic captureRamp(input int inj, input logic [DW-1:0] inj_val, input bit gaps, output int n);
        int cyc;
        logic v;
        n = 0;
        cyc = 0;
        while (!m_done && cyc < 300) begin
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            applyStimulus((n == inj) ? inj_val : DW'(n), v, 1'b0, 1'b0, 1'b0);
            if (v) n++;
            cyc++;
        end
        if (!m_done) begin
            checks++; errors++;
            $display("[TB] FAIL capture_timeout: got done=0 expected done=1");
        end
    endtask

    task automatic doReadout(input int abort_at, input int arm_at);
        seen.delete();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            applyStimulus(DW'($urandom), 1'($urandom), (i == arm_at), (i == abort_at), 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; arm = 0; abort = 0; pre_depth = '0; trig_mask = '0; trig_value = '0;
        sample_in = '0; sample_valid = 0; rd_start = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_wr_en", 32'(ram_bus.ram_wr_en), 0);
        rst = 1'b0;
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("[TB] basic capture");
        armCapture(4, 8'hFF, 8'hA5);
        captureRamp(9, 8'hA5, 0, n);
        checkOutput("basic_samples", 32'(n), 21);
        checkOutput("basic_trig_addr", 32'(trig_addr), 9);
        doReadout(-1, -1);
        checkOutput("basic_count", 32'(seen.size()), 16);
        checkOutput("basic_first", 32'(seen[0]), 32'h05);
        checkOutput("basic_trig", 32'(seen[4]), 32'hA5);
        checkOutput("basic_last", 32'(seen[15]), 32'h14);

        $display("[TB] wrap capture");
        armCapture(4, 8'hFF, 8'hA5);
        captureRamp(29, 8'hA5, 0, n);
        checkOutput("wrap_trig_addr", 32'(trig_addr), 13);
        doReadout(-1, -1);
        checkOutput("wrap_first", 32'(seen[0]), 32'h19);
        checkOutput("wrap_trig", 32'(seen[4]), 32'hA5);
        checkOutput("wrap_last", 32'(seen[15]), 32'h28);
        doReadout(-1, -1);
        checkOutput("reread_first", 32'(seen[0]), 32'h19);

        $display("[TB] pre_depth boundaries");
        armCapture(0, 8'hFF, 8'h3C);
        captureRamp(5, 8'h3C, 0, n);
        checkOutput("pre0_trig_addr", 32'(trig_addr), 5);
        doReadout(-1, -1);
        checkOutput("pre0_first", 32'(seen[0]), 32'h3C);
        armCapture(15, 8'hFF, 8'h77);
        captureRamp(20, 8'h77, 0, n);
        checkOutput("pre15_samples", 32'(n), 21);
        checkOutput("pre15_trig_addr", 32'(trig_addr), 4);
        doReadout(-1, -1);
        checkOutput("pre15_last", 32'(seen[15]), 32'h77);

        $display("[TB] mask zero with gaps");
        armCapture(3, 8'h00, 8'h5A);
        captureRamp(-1, 8'h00, 1, n);
        checkOutput("mask0_trig_addr", 32'(trig_addr), 3);
        checkOutput("mask0_samples", 32'(n), 16);
        doReadout(-1, -1);
        checkOutput("mask0_trig", 32'(seen[3]), 32'h03);

        $display("[TB] abort and ignored commands");
        armCapture(4, 8'hFF, 8'hA5);
        for (int j = 0; j < 9; j++) applyStimulus((j == 6) ? 8'hA5 : DW'(j), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("abort_trig_hold", 32'(trig_addr), 6);
        armCapture(2, 8'hFF, 8'hA5);
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        captureRamp(4, 8'hA5, 0, n);
        pre_depth = 4'd9;
        doReadout(-1, 3);
        doReadout(6, -1);

        $display("[TB] reset during readout");
        armCapture(6, 8'hFF, 8'h5A);
        captureRamp(12, 8'h5A, 0, n);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_rd_addr", 32'(ram_bus.ram_rd_addr), 0);
        checkOutput("rst_trig_addr", 32'(trig_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] randomized captures");
        for (int k = 0; k < 6; k++) begin
            int cyc;
            pre_depth  = AW'($urandom_range(0, DEPTH - 1));
            trig_mask  = DW'($urandom & $urandom & $urandom);
            trig_value = DW'($urandom);
            applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc = 0;
            while (!m_done && cyc < 300) begin
                applyStimulus(DW'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
                cyc++;
            end
            if (m_done) doReadout(-1, -1);
            else applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (3) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Single-clock capture sequencer for the logic-analyzer sample buffer (the 8-bit simple-dual-port `la_ram`, 2^ADDR_WIDTH deep, unregistered read output). It arms on command, fills a circular pre-trigger window, evaluates a masked-value trigger, then finishes a fixed post-trigger count so the buffer holds exactly one full depth of samples. On request it reads the buffer back, oldest sample first, as a valid-qualified stream. Both the RAM write port and the RAM read-address port are driven from this block on the same clock.

## Interface
- ADDR_WIDTH, 17, RAM address width; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, sample and RAM data width.

Ports:
- clk  in  1  capture and readout clock; also drives both RAM clocks.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  start a capture; sampled in IDLE or DONE only.
- abort  in  1  return to IDLE from any state; has priority over all other inputs.
- pre_depth  in  ADDR_WIDTH  pre-trigger sample count, valid range 0..DEPTH-1; latched on accepted arm.
- trig_mask  in  DATA_WIDTH  trigger bit mask; latched on arm.
- trig_value  in  DATA_WIDTH  trigger compare value; latched on arm.
- sample_in  in  DATA_WIDTH  probe sample.
- sample_valid  in  1  sample_in is valid this cycle.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data; valid one clk after ram_rd_addr.
- rd_start  in  1  begin readout; sampled in DONE only.
- rd_data  out  DATA_WIDTH  readout sample; equals ram_rd_data.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  final readout sample; coincident with rd_valid.
- trig_addr  out  ADDR_WIDTH  RAM address holding the trigger sample.
- done  out  1  capture complete and buffer readable (state DONE).
- busy  out  1  state is PRE, WAIT_TRIG, POST or READ.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE, READ.
- Reset: state IDLE; all outputs and internal pointers/counters 0.
- IDLE/DONE + arm: latch pre_depth, trig_mask and trig_value; clear wr_ptr and the counters. Go to PRE, or to WAIT_TRIG if pre_depth = 0.
- Every accepted sample (sample_valid=1 in PRE, WAIT_TRIG or POST) is written at wr_ptr; wr_ptr increments mod DEPTH.
- PRE: count writes. After pre_depth writes, go to WAIT_TRIG. The trigger is not evaluated in PRE.
- WAIT_TRIG: a sample matches when ((sample_in ^ trig_value) & trig_mask) == 0. trig_mask = 0 matches the first sample. The matching sample is written, trig_addr <= its address, and the state goes to POST, or directly to DONE if DEPTH-1-pre_depth = 0. Non-matching samples keep overwriting circularly.
- POST: after DEPTH-1-pre_depth further writes, go to DONE.
- DONE + rd_start: start_addr = trig_addr - pre_depth (mod DEPTH). Go to READ and issue DEPTH read addresses start_addr, start_addr+1, ..., one per cycle, wrapping mod DEPTH. After the last address issues, return to DONE. Re-reading is allowed.
- abort: state goes to IDLE at the next edge. ram_wr_en and rd_valid are 0 from the following cycle. trig_addr holds its value.
- Ignored inputs: arm in PRE/WAIT_TRIG/POST/READ; rd_start outside DONE; sample_valid outside the capture states.
- All address arithmetic is ADDR_WIDTH bits, modulo. Counters are ADDR_WIDTH+1 bits.

## Timing
- Write path is registered: sample_valid high in cycle n → ram_wr_en, ram_wr_addr, ram_wr_data in cycle n+1.
- The trigger compare is combinational on sample_in in cycle n. The state change is visible in cycle n+1.
- done rises in the same cycle as the final ram_wr_en. That write completes at the end of the cycle, before any read address can be issued.
- Readout: rd_start sampled at edge k → ram_rd_addr = start_addr in cycle k+1. rd_valid is high in cycles k+2 .. k+1+DEPTH. rd_last is high in cycle k+1+DEPTH only.
- busy = 0 and done = 1 in the cycle after the last read address is issued; rd_valid may still be high in that cycle.
- Throughput: one sample per clk on both capture and readout. There is no backpressure.

## Test plan
(All scenarios use ADDR_WIDTH=4, DEPTH=16.)
- Basic capture: pre_depth=4, trig_mask=FF, trig_value=A5; ramp 00,01,… with A5 injected at the 10th sample → trig_addr=9; done after 11 post writes; readout returns 16 samples starting 4 before A5, rd_last on the 16th.
- Wrap: pre_depth=4, trigger at sample 30 → trig_addr=13 (30 mod 16 = 14, minus 1 for zero-based = 13 address of 30th sample index 29); readout start_addr=9, addresses wrap 15→0, oldest-first order correct.
- Boundaries: pre_depth=0 → the trigger sample is the first sample read out. pre_depth=15 → no POST; done in the same cycle as the trigger write; the trigger sample is the last sample read out.
- Masked/immediate trigger and gaps: trig_mask=0 with sample_valid toggling every other cycle → ram_wr_en only in cycles following a valid sample; trigger on first sample after PRE.
- Abort and ignored commands: abort mid-POST → IDLE, no further writes. abort mid-READ → rd_valid 0 from the cycle after the IDLE transition. arm during READ and rd_start during WAIT_TRIG → no effect.
- Reset: assert rst asynchronously mid-READ → all outputs 0 immediately; state IDLE after release.
